// File: rtl/mem_turn_ctrl_if.sv
// Scorer-facing bus of the memory game controller: pick strobe with the
// picked card value and pickability flag, the current player, and the
// scorer's 2-bit result code coming back.
interface mem_turn_ctrl_if #(
  parameter int VW = 4
);
  logic          select;
  logic [VW-1:0] state;
  logic          empty;
  logic          player;
  logic [1:0]    x;

  modport master (
    output select,
    output state,
    output empty,
    output player,
    input  x
  );

  modport slave (
    input  select,
    input  state,
    input  empty,
    input  player,
    output x
  );
endinterface

// File: rtl/mem_turn_ctrl.sv
// Game-side controller for the memory card game. Holds the board, takes
// picks from cursor/button, hands each pick to the scorer, resolves the
// pair as match or mismatch, hides mismatched pairs after a display hold,
// alternates players and latches the scorer's final verdict.
module mem_turn_ctrl #(
  parameter int  NCARDS      = 16,
  parameter int  HOLD_CYCLES = 50000000,
  parameter int  ACK_TIMEOUT = 16,
  localparam int AW          = $clog2(NCARDS),
  localparam int PW          = $clog2(NCARDS / 2 + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_en,
  input  logic [AW-1:0]       load_addr,
  input  logic [AW-1:0]       load_val,
  input  logic                start,
  input  logic [AW-1:0]       cursor,
  input  logic                btn,
  mem_turn_ctrl_if.master     sb,
  output logic [NCARDS-1:0]   revealed,
  output logic [NCARDS-1:0]   matched,
  output logic [PW-1:0]       pairs_left,
  output logic                game_over,
  output logic [1:0]          result,
  output logic                ack_err
);

  // Counters only ever reach LIMIT-1 before the state moves on, so they
  // are sized for that and can never wrap.
  localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int ACW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
  localparam logic [ACW-1:0] ACK_LAST  = ACW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, PICK1, PICK2, WAIT_ACK, HOLD, FINAL, DONE
  } st_t;

  st_t            st, st_nxt;
  logic [AW-1:0]  board [NCARDS];
  logic [AW-1:0]  p1, p2, v1, v2;
  logic [AW-1:0]  cur_val;
  logic           btn_q;
  logic           pick, pick_ok;
  logic [HCW-1:0] hold_cnt;
  logic [ACW-1:0] ack_cnt;
  logic           hold_done, ack_to, ack_counting;
  logic           fin_sent;
  logic           sel_r, empty_r, player_r;
  logic [AW-1:0]  state_r;

  logic load_we, start_game, take, eval, ack_miss;
  logic hold_end, fin_issue, fin_take, fin_to;

  assign sb.select = sel_r;
  assign sb.state  = state_r;
  assign sb.empty  = empty_r;
  assign sb.player = player_r;

  assign game_over    = (st == DONE);
  assign cur_val      = board[cursor];
  assign pick         = btn & ~btn_q;
  assign pick_ok      = pick & ~matched[cursor] & ~revealed[cursor];
  assign hold_done    = (hold_cnt == HOLD_LAST);
  assign ack_to       = (ack_cnt == ACK_LAST);
  assign ack_counting = (st == WAIT_ACK) || ((st == FINAL) && fin_sent);

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st <= IDLE;
    else      st <= st_nxt;
  end

  // Next-state decode and per-cycle action strobes
  always_comb begin
    st_nxt     = st;
    load_we    = 1'b0;
    start_game = 1'b0;
    take       = 1'b0;
    eval       = 1'b0;
    ack_miss   = 1'b0;
    hold_end   = 1'b0;
    fin_issue  = 1'b0;
    fin_take   = 1'b0;
    fin_to     = 1'b0;
    case (st)
      IDLE: begin
        load_we = load_en;
        if (start) begin
          start_game = 1'b1;
          st_nxt     = PICK1;
        end
      end
      PICK1: begin
        if (pick_ok) begin
          take   = 1'b1;
          st_nxt = PICK2;
        end
      end
      PICK2: begin
        if (pick_ok) begin
          take   = 1'b1;
          st_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // Any non-zero code counts as the turn acknowledgement.
        if ((sb.x != 2'b00) || ack_to) begin
          eval     = 1'b1;
          ack_miss = (sb.x == 2'b00);
          if (v1 == v2) st_nxt = (pairs_left == PW'(1)) ? FINAL : PICK1;
          else          st_nxt = HOLD;
        end
      end
      HOLD: begin
        if (hold_done) begin
          hold_end = 1'b1;
          st_nxt   = PICK1;
        end
      end
      FINAL: begin
        // First cycle only issues the closing select, leaving a gap after
        // the last turn's select; the verdict is watched from then on.
        if (!fin_sent) begin
          fin_issue = 1'b1;
        end else if (sb.x[1]) begin
          fin_take = 1'b1;
          st_nxt   = DONE;
        end else if (ack_to) begin
          fin_to = 1'b1;
          st_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          start_game = 1'b1;
          st_nxt     = PICK1;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Game control state: masks, player, counters, scorer strobe, verdict
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_q      <= 1'b0;
      sel_r      <= 1'b0;
      state_r    <= '0;
      empty_r    <= 1'b0;
      player_r   <= 1'b0;
      revealed   <= '0;
      matched    <= '0;
      pairs_left <= PW'(NCARDS / 2);
      result     <= 2'b00;
      ack_err    <= 1'b0;
      hold_cnt   <= '0;
      ack_cnt    <= '0;
      fin_sent   <= 1'b0;
    end else begin
      btn_q   <= btn;
      sel_r   <= 1'b0;
      state_r <= '0;
      empty_r <= 1'b0;

      if (start_game) begin
        revealed   <= '0;
        matched    <= '0;
        player_r   <= 1'b0;
        pairs_left <= PW'(NCARDS / 2);
        result     <= 2'b00;
      end

      if (take) begin
        revealed[cursor] <= 1'b1;
        sel_r            <= 1'b1;
        state_r          <= cur_val;
        empty_r          <= 1'b1;
      end

      if (eval && (v1 == v2)) begin
        matched[p1] <= 1'b1;
        matched[p2] <= 1'b1;
        pairs_left  <= pairs_left - 1'b1;
      end
      if (eval && ack_miss) ack_err <= 1'b1;

      if (hold_end) begin
        revealed[p1] <= 1'b0;
        revealed[p2] <= 1'b0;
        player_r     <= ~player_r;
      end

      if (fin_issue) begin
        sel_r   <= 1'b1;
        state_r <= v2;
        empty_r <= 1'b1;
      end
      if (fin_take) result <= sb.x;
      if (fin_to) begin
        result  <= 2'b00;
        ack_err <= 1'b1;
      end

      hold_cnt <= ((st == HOLD) && !hold_done) ? hold_cnt + 1'b1 : '0;
      ack_cnt  <= (ack_counting && (st_nxt == st)) ? ack_cnt + 1'b1 : '0;

      if (st != FINAL)    fin_sent <= 1'b0;
      else if (fin_issue) fin_sent <= 1'b1;
    end
  end

  // Board RAM; deliberately not reset so a new game reuses the layout
  always_ff @(posedge clk) begin
    if (load_we) board[load_addr] <= load_val;
  end

  // Picked positions and values of the current turn
  always_ff @(posedge clk) begin
    if (take && (st == PICK1)) begin
      p1 <= cursor;
      v1 <= cur_val;
    end
    if (take && (st == PICK2)) begin
      p2 <= cursor;
      v2 <= cur_val;
    end
  end

endmodule

// File: tb/tb_mem_turn_ctrl.sv
// Bench for mem_turn_ctrl: game-level reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_mem_turn_ctrl;
  localparam int NC   = 16;
  localparam int HOLD = 8;
  localparam int ACKT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [3:0]  load_val = '0;
  logic        start = 1'b0;
  logic [3:0]  cursor = '0;
  logic        btn = 1'b0;
  logic [15:0] revealed, matched;
  logic [3:0]  pairs_left;
  logic        game_over;
  logic [1:0]  result;
  logic        ack_err;

  mem_turn_ctrl_if #(.VW(4)) sb ();

  mem_turn_ctrl #(.NCARDS(NC), .HOLD_CYCLES(HOLD), .ACK_TIMEOUT(ACKT)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_val(load_val), .start(start), .cursor(cursor), .btn(btn),
    .sb(sb), .revealed(revealed), .matched(matched), .pairs_left(pairs_left),
    .game_over(game_over), .result(result), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- game-level reference model ----------------
  bit [3:0] mb [16];
  bit       mup [16];
  bit       mdn [16];
  bit       mpl, merr, fsent, bprev, esel, eempty;
  bit [1:0] mres;
  bit [3:0] estate, mlast;
  int       mpairs, phase, tmr;   // phase: 0 idle 1 picking 2 ack 3 hold 4 final 5 done
  int       pq[$];

  function automatic logic [15:0] pack(input bit a[16]);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[i] = a[i];
    return r;
  endfunction

  task automatic new_game();
    for (int i = 0; i < 16; i++) begin
      mup[i] = 1'b0;
      mdn[i] = 1'b0;
    end
    mpl = 1'b0; mpairs = NC / 2; mres = 2'b00; phase = 1; pq.delete();
  endtask

  always @(posedge clk or negedge rst) begin : model
    bit pk;
    if (!rst) begin
      for (int i = 0; i < 16; i++) begin
        mup[i] = 1'b0;
        mdn[i] = 1'b0;
      end
      mpl = 1'b0; mpairs = NC / 2; mres = 2'b00; merr = 1'b0; phase = 0;
      tmr = 0; pq.delete(); fsent = 1'b0; bprev = 1'b0;
      esel = 1'b0; estate = '0; eempty = 1'b0;
    end else begin
      pk = btn && !bprev;
      bprev = btn;
      esel = 1'b0; estate = '0; eempty = 1'b0;
      case (phase)
        0: begin
          if (load_en) mb[load_addr] = load_val;
          if (start) new_game();
        end
        1: if (pk && !mup[cursor] && !mdn[cursor]) begin
          mup[cursor] = 1'b1;
          pq.push_back(int'(cursor));
          esel = 1'b1; estate = mb[cursor]; eempty = 1'b1;
          mlast = mb[cursor];
          if (pq.size() == 2) begin
            phase = 2;
            tmr = ACKT;
          end
        end
        2: begin
          tmr--;
          if (sb.x != 2'b00 || tmr == 0) begin
            if (sb.x == 2'b00) merr = 1'b1;
            if (mb[pq[0]] == mb[pq[1]]) begin
              mdn[pq[0]] = 1'b1;
              mdn[pq[1]] = 1'b1;
              mpairs--;
              pq.delete();
              phase = (mpairs == 0) ? 4 : 1;
              fsent = 1'b0;
            end else begin
              phase = 3;
              tmr = HOLD;
            end
          end
        end
        3: begin
          tmr--;
          if (tmr == 0) begin
            mup[pq[0]] = 1'b0;
            mup[pq[1]] = 1'b0;
            pq.delete();
            mpl = !mpl;
            phase = 1;
          end
        end
        4: begin
          if (!fsent) begin
            fsent = 1'b1;
            esel = 1'b1; estate = mlast; eempty = 1'b1;
            tmr = ACKT;
          end else begin
            tmr--;
            if (sb.x[1]) begin
              mres = sb.x;
              phase = 5;
            end else if (tmr == 0) begin
              merr = 1'b1;
              mres = 2'b00;
              phase = 5;
            end
          end
        end
        5: if (start) new_game();
        default: phase = 0;
      endcase
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    chk("select", sb.select, esel);
    if (esel) begin
      chk("state", sb.state, estate);
      chk("empty", sb.empty, eempty);
    end
    chk("player", sb.player, mpl);
    chk("revealed", revealed, pack(mup));
    chk("matched", matched, pack(mdn));
    chk("pairs_left", pairs_left, mpairs);
    chk("game_over", game_over, phase == 5);
    chk("result", result, mres);
    chk("ack_err", ack_err, merr);
  end

  // Select monitor for directed count checks
  int       sel_cnt = 0;
  int       st_sum = 0;
  logic [3:0] last_st = '0;
  always @(negedge clk) begin
    if (sb.select === 1'b1) begin
      sel_cnt++;
      st_sum += int'(sb.state);
      last_st = sb.state;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int pos);
    cursor = 4'(pos);
    btn = 1'b1;
    tick(1);
    btn = 1'b0;
    tick(1);
  endtask

  task automatic ack1();
    sb.x = 2'b01;
    tick(1);
    sb.x = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish within time limit");
    $fatal(1);
  end

  initial begin
    int base, sbase;
    bit seen;
    int prs[6];
    prs = '{2, 4, 8, 10, 12, 14};
    sb.x = 2'b00;
    #1 rst = 1'b0;
    tick(2);
    chk("rst_pairs", pairs_left, 8);
    chk("rst_select", sb.select, 0);
    chk("rst_revealed", revealed, 0);
    chk("rst_game_over", game_over, 0);
    chk("rst_result", result, 0);
    chk("rst_ack_err", ack_err, 0);
    rst = 1'b1;
    tick(1);

    for (int i = 0; i < 16; i++) begin
      load_en = 1'b1; load_addr = 4'(i); load_val = 4'(i >> 1);
      tick(1);
    end
    load_en = 1'b0;
    start = 1'b1; tick(1); start = 1'b0; tick(1);

    // matching first pair
    base = sel_cnt; sbase = st_sum;
    press(0); press(1); tick(1); ack1(); tick(2);
    chk("s1_matched", matched, 16'h0003);
    chk("s1_pairs", pairs_left, 7);
    chk("s1_player", sb.player, 0);
    chk("s1_selects", sel_cnt - base, 2);
    chk("s1_state_sum", st_sum - sbase, 0);

    // mismatch and hold
    press(2); press(4); tick(1); ack1();
    chk("s2_rev_hold0", revealed, 16'h0017);
    tick(7);
    chk("s2_rev_hold7", revealed, 16'h0017);
    tick(1);
    chk("s2_rev_after", revealed, 16'h0003);
    chk("s2_player", sb.player, 1);

    // matched card ignored, held button gives one pick
    base = sel_cnt;
    press(0);
    cursor = 4'd6; btn = 1'b1; tick(20); btn = 1'b0; tick(2);
    chk("s3_selects", sel_cnt - base, 1);
    chk("s3_state", last_st, 3);
    chk("s3_revealed", revealed, 16'h0043);

    // ack timeout on a matching pair
    press(7);
    tick(14);
    chk("s4_err_before", ack_err, 0);
    tick(1);
    chk("s4_err_after", ack_err, 1);
    chk("s4_matched", matched, 16'h00C3);
    chk("s4_pairs", pairs_left, 6);

    // ack timeout on a mismatching pair
    press(8); press(10); tick(ACKT + HOLD + 2);
    chk("s4b_player", sb.player, 0);
    chk("s4b_revealed", revealed, 16'h00C3);

    // finish the board
    foreach (prs[k]) begin
      press(prs[k]); press(prs[k] + 1); tick(1); ack1(); tick(1);
    end
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      if (sb.select === 1'b1) seen = 1'b1;
      else tick(1);
    end
    chk("s5_final_select_seen", seen, 1);
    chk("s5_final_state", sb.state, 7);
    sb.x = 2'b11; tick(1); sb.x = 2'b00; tick(1);
    chk("s5_game_over", game_over, 1);
    chk("s5_result", result, 2'b11);
    chk("s5_pairs", pairs_left, 0);
    chk("s5_matched", matched, 16'hFFFF);

    // new game, reset in the middle of a hold
    start = 1'b1; tick(1); start = 1'b0;
    press(0); press(2); tick(1); ack1(); tick(3);
    chk("s6_rev_hold", revealed, 16'h0005);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("s6_rst_revealed", revealed, 0);
    chk("s6_rst_matched", matched, 0);
    chk("s6_rst_pairs", pairs_left, 8);
    chk("s6_rst_ack_err", ack_err, 0);
    chk("s6_rst_select", sb.select, 0);
    chk("s6_rst_game_over", game_over, 0);
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    start = 1'b1; tick(1); start = 1'b0;
    press(0); press(1); tick(1); ack1(); tick(2);
    chk("s6_matched", matched, 16'h0003);
    chk("s6_pairs", pairs_left, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_turn_ctrl.md
Name: mem_turn_ctrl

Overview:
- Game-side controller for the memory card game; it sits upstream of the turn scorer.
- Holds the 16-card board and tracks revealed and matched cards, and takes player picks from the cursor and button.
- Drives the scorer's select/state/empty/player inputs and consumes the scorer's 2-bit result code x.
- Decides match or mismatch, hides unmatched pairs after a display hold, alternates players, and latches the end-of-game result.

Parameters:
- NCARDS, 16, number of board positions; must be even; pairs = NCARDS/2.
- HOLD_CYCLES, 50000000, cycles a mismatched pair stays revealed before hiding.
- ACK_TIMEOUT, 16, max cycles to wait for scorer code 01 after a pick pair.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- load_en  in  1  board write strobe; honoured only in state IDLE
- load_addr  in  4  board position to write
- load_val  in  4  card value to write
- start  in  1  level; begins a game from IDLE
- cursor  in  4  currently pointed board position
- btn  in  1  raw pick button, synchronous to clk
- x  in  2  scorer result: 00 none, 01 turn evaluated, 10 winner decided, 11 tie
- select  out  1  one-cycle pick strobe to scorer
- state  out  4  card value at the picked position, valid with select
- empty  out  1  1 = picked position was pickable, valid with select
- player  out  1  current player (0 = J1, 1 = J2)
- revealed  out  16  face-up mask (includes matched)
- matched  out  16  matched-card mask
- pairs_left  out  4  unmatched pairs remaining
- game_over  out  1  high in DONE
- result  out  2  latched final code from x (10/11); 00 until latched
- ack_err  out  1  sticky; set on any ACK_TIMEOUT expiry

Behaviour:
- Reset (async, rst=0) affects control state only; the board value RAM is not reset.
  - Outputs go to: select=0, state=0, empty=0, player=0, revealed=0, matched=0, pairs_left=NCARDS/2, game_over=0, result=00, ack_err=0.
  - FSM goes to IDLE; the btn edge register is cleared.
  - Reset mid-game abandons the game immediately.
- Button: pick = btn & ~btn_q, a rising edge. Holding btn yields exactly one pick.
- Pickable(p): matched[p]=0 and revealed[p]=0.
- FSM states: IDLE, PICK1, PICK2, WAIT_ACK, HOLD, FINAL, DONE.
- IDLE:
  - load_en writes board[load_addr].
  - start=1 clears revealed/matched, sets player=0, pairs_left=NCARDS/2, result=00, and goes to PICK1.
- PICK1, on pick with cursor pickable:
  - Set revealed[cursor], latch p1=cursor and v1=board[cursor].
  - Next cycle drive select=1, state=v1, empty=1; go to PICK2.
  - Picks of non-pickable cards are ignored, with no select.
- PICK2: same rules as PICK1 (latch p2/v2). Because p1 is already revealed, re-picking p1 is ignored. After select, go to WAIT_ACK.
- Pick-to-select latency is 1 cycle. select never stays high for two consecutive cycles.
- WAIT_ACK: wait for x==01; 10/11 are also accepted as the ack.
  - On ack or after ACK_TIMEOUT cycles, evaluate the pair. On timeout also set ack_err.
  - Match (v1==v2): set matched[p1], matched[p2] and decrement pairs_left; player is unchanged. If pairs_left becomes 0, go to FINAL, else go to PICK1.
  - Mismatch: go to HOLD.
- HOLD:
  - Count HOLD_CYCLES, then clear revealed[p1] and revealed[p2], toggle player, and go to PICK1.
  - Picks during HOLD are discarded.
- FINAL: issue one select with state=v2, empty=1, then wait for x in {10,11}, bounded by ACK_TIMEOUT.
  - On receipt, latch result=x.
  - On timeout, set result=00 and set ack_err.
  - Either way, go to DONE.
- DONE: game_over=1, and result holds its latched value. start=1 starts a new game, from the same board contents, as from IDLE.
- x=00/01 outside WAIT_ACK and FINAL is ignored.
- Counter widths: size the hold counter for HOLD_CYCLES and the ack counter for ACK_TIMEOUT; neither may wrap.

Test Plan:
- Load board[i]=i>>1, start, pick 0 then 1, scorer returns x=01 two cycles after the second select -> matched=0x0003, pairs_left=7, player=0, exactly two 1-cycle selects with state=0.
- Pick 2 then 4 (values 1, 2), x=01 -> HOLD; revealed=0x0017 for HOLD_CYCLES (bench uses 8), then revealed=0x0003 and player=1.
- Pick 0 (already matched), then hold btn high 20 cycles on position 6 -> no select for position 0, exactly one select for position 6 with state=3.
- Second pick, x held at 00 -> after 16 cycles ack_err=1 and the pair is still evaluated (match clears the pair; mismatch enters HOLD).
- Match all 8 pairs, scorer answers the FINAL select with x=11 -> game_over=1, result=11, pairs_left=0.
- Reset asserted during HOLD -> all outputs at reset values immediately; after release, start with unchanged board works.
